// File: rtl/decode_issue_ctrl.sv
// Fetch-to-decode issue controller: small instruction FIFO plus per-register load-latency scoreboard.
// Latency: min 1 cycle fetch-to-issue; dependents of a load wait LOAD_LATENCY bubbles after it issues.
// Backpressure: fetch_ready drops when the FIFO is full; stall freezes FIFO and scoreboard, flush empties FIFO.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall, flush              global freeze / taken-branch squash of buffered instructions
//   fetch_valid/ready/instr   instruction handshake from fetch
//   issue_instr, issue_valid  instruction presented to decode (NOP_INSTR on bubble)
//   data_hazard               FIFO head blocked by a pending load result
//   issue_is_load, issue_dest control decode of issue_instr, fed back to arm the scoreboard
//   occupancy                 current FIFO entry count
module decode_issue_ctrl #(
   parameter int                     INSTR_WIDTH   = 16,
   parameter int                     REG_SEL_WIDTH = 3,
   parameter int                     RS_LSB        = 8,
   parameter int                     RT_LSB        = 5,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR     = 16'h0800,
   parameter int                     BUF_DEPTH     = 2,
   parameter int                     LOAD_LATENCY  = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         flush,
   input  logic                         fetch_valid,
   input  logic [INSTR_WIDTH-1:0]       fetch_instr,
   output logic                         fetch_ready,
   output logic [INSTR_WIDTH-1:0]       issue_instr,
   output logic                         issue_valid,
   output logic                         data_hazard,
   input  logic                         issue_is_load,
   input  logic [REG_SEL_WIDTH-1:0]     issue_dest,
   output logic [$clog2(BUF_DEPTH):0]   occupancy
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
   localparam int SB_W  = $clog2(LOAD_LATENCY + 1);
   localparam int NREG  = 2 ** REG_SEL_WIDTH;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
   localparam logic [SB_W-1:0]  SB_ARM   = SB_W'(LOAD_LATENCY);

   logic [INSTR_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [CNT_W-1:0]       count;
   logic [SB_W-1:0]        sb_cnt [NREG];

   logic                     push;
   logic                     pop;
   logic                     not_empty;
   logic [INSTR_WIDTH-1:0]   head;
   logic [REG_SEL_WIDTH-1:0] head_rs;
   logic [REG_SEL_WIDTH-1:0] head_rt;

   assign head      = mem[rd_ptr];
   assign head_rs   = head[RS_LSB +: REG_SEL_WIDTH];
   assign head_rt   = head[RT_LSB +: REG_SEL_WIDTH];
   assign not_empty = (count != '0);

   assign fetch_ready = (count != FULL_CNT);
   assign push        = fetch_valid & fetch_ready & ~stall & ~flush;

   // Both source fields are checked regardless of opcode; over-stalling an
   // instruction that ignores rt is cheaper than decoding formats here.
   assign data_hazard = not_empty & ~flush &
                        ((sb_cnt[head_rs] != '0) | (sb_cnt[head_rt] != '0));
   assign pop         = not_empty & ~data_hazard & ~stall & ~flush;

   assign issue_instr = pop ? head : NOP_INSTR;
   assign issue_valid = pop;
   assign occupancy   = count;

   // Storage needs no reset: entries are only visible once count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= fetch_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int r = 0; r < NREG; r++) begin
            sb_cnt[r] <= '0;
         end
      end else begin
         // Flush beats stall for the FIFO: younger instructions are dead either way.
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
               count <= count + CNT_W'(1);
            end else if (pop && !push) begin
               count <= count - CNT_W'(1);
            end
         end

         // Scoreboard survives flush: the loads it tracks are older than the
         // branch and still in flight. It only freezes on stall.
         if (!stall) begin
            for (int r = 0; r < NREG; r++) begin
               if (sb_cnt[r] != '0) begin
                  sb_cnt[r] <= sb_cnt[r] - SB_W'(1);
               end
            end
            // Later assignment wins, so a new load re-arms over the decrement.
            if (pop && issue_is_load) begin
               sb_cnt[issue_dest] <= SB_ARM;
            end
         end
      end
   end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed and random checks of decode_issue_ctrl in two configurations.
// Latency: n/a (testbench).
// Backpressure: fetch model holds fetch_valid/fetch_instr until accepted.
module tb_decode_issue_ctrl;

    localparam logic [15:0] NOP = 16'h0800;
    localparam logic [15:0] LD  = 16'h8940;   // load r2 <- [r1]
    localparam logic [15:0] ADD = 16'hDA8C;   // reads r2, r4
    localparam logic [15:0] IND = 16'h05C0;   // reads r5, r6

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT a: default configuration (BUF_DEPTH 2, LOAD_LATENCY 1)
    logic        a_stall = 1'b0, a_flush = 1'b0, a_fv = 1'b0;
    logic [15:0] a_fi = '0;
    logic        a_fr, a_iv, a_dh, a_ld;
    logic [15:0] a_ii;
    logic [2:0]  a_dst;
    logic [1:0]  a_occ;

    // DUT b: BUF_DEPTH 4, LOAD_LATENCY 3
    logic        b_stall = 1'b0, b_flush = 1'b0, b_fv = 1'b0;
    logic [15:0] b_fi = '0;
    logic        b_fr, b_iv, b_dh, b_ld;
    logic [15:0] b_ii;
    logic [2:0]  b_dst;
    logic [2:0]  b_occ;

    // Control-decode stand-in: opcode 4'h8 is a load, destination is the rt field.
    assign a_ld  = a_iv && (a_ii[15:12] == 4'h8);
    assign a_dst = a_ii[7:5];
    assign b_ld  = b_iv && (b_ii[15:12] == 4'h8);
    assign b_dst = b_ii[7:5];

    decode_issue_ctrl u_a (
        .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush),
        .fetch_valid(a_fv), .fetch_instr(a_fi), .fetch_ready(a_fr),
        .issue_instr(a_ii), .issue_valid(a_iv), .data_hazard(a_dh),
        .issue_is_load(a_ld), .issue_dest(a_dst), .occupancy(a_occ)
    );

    decode_issue_ctrl #(.BUF_DEPTH(4), .LOAD_LATENCY(3)) u_b (
        .clk(clk), .rst(rst), .stall(b_stall), .flush(b_flush),
        .fetch_valid(b_fv), .fetch_instr(b_fi), .fetch_ready(b_fr),
        .issue_instr(b_ii), .issue_valid(b_iv), .data_hazard(b_dh),
        .issue_is_load(b_ld), .issue_dest(b_dst), .occupancy(b_occ)
    );

    task automatic fail(string tag);
        bad++;
        $error("FAIL %s", tag);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ck_a(string tag, logic iv, logic [15:0] ii, logic dh);
        #1;
        total += 3;
        if (a_iv !== iv) fail({tag, ".valid"});
        if (a_ii !== ii) fail({tag, ".instr"});
        if (a_dh !== dh) fail({tag, ".hazard"});
    endtask

    task automatic ck_b(string tag, logic iv, logic [15:0] ii, logic dh);
        #1;
        total += 3;
        if (b_iv !== iv) fail({tag, ".valid"});
        if (b_ii !== ii) fail({tag, ".instr"});
        if (b_dh !== dh) fail({tag, ".hazard"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q[$];
        int          sbm[8];
        int          sent, got;
        logic        acc, ok;
        logic [15:0] expv;

        // ---------------- reset ----------------
        cyc(); cyc();
        rst = 1'b0;
        ck_a("rst_a", 1'b0, NOP, 1'b0);
        total++; if (a_fr !== 1'b1) fail("rst_a.ready");
        total++; if (a_occ !== 2'd0) fail("rst_a.occ");
        ck_b("rst_b", 1'b0, NOP, 1'b0);
        total++; if (b_fr !== 1'b1) fail("rst_b.ready");
        total++; if (b_occ !== 3'd0) fail("rst_b.occ");
        cyc();

        // ---------------- load-use, latency 1 ----------------
        a_fv = 1'b1; a_fi = LD;  ck_a("l1_c0", 1'b0, NOP, 1'b0); cyc();
        a_fi = ADD;              ck_a("l1_c1", 1'b1, LD,  1'b0); cyc();
        a_fv = 1'b0;             ck_a("l1_c2", 1'b0, NOP, 1'b1); cyc();
                                 ck_a("l1_c3", 1'b1, ADD, 1'b0); cyc();
                                 ck_a("l1_c4", 1'b0, NOP, 1'b0);
        total++; if (a_occ !== 2'd0) fail("l1_c4.occ");
        cyc();

        // ---------------- load-use, latency 3: three bubbles ----------------
        b_fv = 1'b1; b_fi = LD;  ck_b("l3_c0", 1'b0, NOP, 1'b0); cyc();
        b_fi = ADD;              ck_b("l3_c1", 1'b1, LD,  1'b0); cyc();
        b_fv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ck_b("l3_bubble", 1'b0, NOP, 1'b1); cyc();
        end
        ck_b("l3_add", 1'b1, ADD, 1'b0); cyc();

        // ---------------- independent instruction fills a bubble slot ----------------
        b_fv = 1'b1; b_fi = LD;  ck_b("ind_c0", 1'b0, NOP, 1'b0); cyc();
        b_fi = IND;              ck_b("ind_c1", 1'b1, LD,  1'b0); cyc();
        b_fi = ADD;              ck_b("ind_c2", 1'b1, IND, 1'b0); cyc();
        b_fv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ck_b("ind_bubble", 1'b0, NOP, 1'b1); cyc();
        end
        ck_b("ind_add", 1'b1, ADD, 1'b0); cyc();

        // ---------------- stall freezes a pending hazard ----------------
        b_fv = 1'b1; b_fi = LD;  ck_b("st_c0", 1'b0, NOP, 1'b0); cyc();
        b_fi = ADD;              ck_b("st_c1", 1'b1, LD,  1'b0); cyc();
        b_fv = 1'b0;             ck_b("st_c2", 1'b0, NOP, 1'b1); cyc();
        b_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ck_b("st_frozen", 1'b0, NOP, 1'b1);
            total++; if (b_occ !== 3'd1) fail("st_frozen.occ");
            cyc();
        end
        b_stall = 1'b0;
        ck_b("st_c7", 1'b0, NOP, 1'b1); cyc();
        ck_b("st_c8", 1'b0, NOP, 1'b1); cyc();
        ck_b("st_c9", 1'b1, ADD, 1'b0); cyc();

        // ---------------- fill to full behind a blocked head, then flush ----------------
        b_fv = 1'b1; b_fi = LD;  ck_b("fl_c0", 1'b0, NOP, 1'b0); cyc();
        b_fi = ADD;              ck_b("fl_c1", 1'b1, LD,  1'b0); cyc();
        b_fi = 16'h1111;         ck_b("fl_c2", 1'b0, NOP, 1'b1); cyc();
        b_fi = 16'h2222;         ck_b("fl_c3", 1'b0, NOP, 1'b1); cyc();
        b_fi = 16'h3333;         ck_b("fl_c4", 1'b0, NOP, 1'b1); cyc();
        b_fi = 16'h4444; b_flush = 1'b1;
        ck_b("fl_full", 1'b0, NOP, 1'b0);
        total++; if (b_fr !== 1'b0) fail("fl_full.ready");
        total++; if (b_occ !== 3'd4) fail("fl_full.occ");
        cyc();
        b_flush = 1'b0; b_fv = 1'b0;
        ck_b("fl_after", 1'b0, NOP, 1'b0);
        total++; if (b_fr !== 1'b1) fail("fl_after.ready");
        total++; if (b_occ !== 3'd0) fail("fl_after.occ");
        cyc();

        // ---------------- pending load count survives a flush ----------------
        b_fv = 1'b1; b_fi = LD;  ck_b("sv_d0", 1'b0, NOP, 1'b0); cyc();
        b_fv = 1'b0;             ck_b("sv_d1", 1'b1, LD,  1'b0); cyc();
        b_flush = 1'b1;          ck_b("sv_d2", 1'b0, NOP, 1'b0); cyc();
        b_flush = 1'b0; b_fv = 1'b1; b_fi = ADD;
                                 ck_b("sv_d3", 1'b0, NOP, 1'b0); cyc();
        b_fv = 1'b0;             ck_b("sv_d4", 1'b0, NOP, 1'b1); cyc();
                                 ck_b("sv_d5", 1'b1, ADD, 1'b0); cyc();
        for (int i = 0; i < 4; i++) cyc();

        // ---------------- random traffic with stall and held fetch ----------------
        for (int r = 0; r < 8; r++) sbm[r] = 0;
        sent = 0; got = 0;
        for (int c = 0; c < 4000 && got < 50; c++) begin
            b_stall = ($urandom_range(0, 3) == 0);
            if (!b_fv && sent < 50 && $urandom_range(0, 1) == 1) begin
                b_fv = 1'b1;
                b_fi = 16'($urandom);
                if ($urandom_range(0, 2) == 0) b_fi[15:12] = 4'h8;
            end
            #1;
            if (b_iv) begin
                expv = (q.size() > 0) ? q.pop_front() : NOP;
                total++; if (b_ii !== expv) fail("rnd_order");
                ok = (sbm[b_ii[10:8]] == 0) && (sbm[b_ii[7:5]] == 0);
                total++; if (ok !== 1'b1) fail("rnd_no_hazard_issue");
                got++;
            end
            acc = b_fv && b_fr && !b_stall;
            if (acc) begin
                q.push_back(b_fi);
                sent++;
            end
            if (!b_stall) begin
                for (int r = 0; r < 8; r++) if (sbm[r] > 0) sbm[r]--;
                if (b_iv && b_ii[15:12] == 4'h8) sbm[b_ii[7:5]] = 3;
            end
            cyc();
            if (acc) b_fv = 1'b0;
        end
        b_stall = 1'b0;
        total++; if (got !== 50) fail("rnd_issued_count");
        total++; if (q.size() !== 0) fail("rnd_queue_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Parametrised fetch-to-decode issue controller. It replaces the single-entry "previous instruction" hold and the fixed load-use check with a small instruction FIFO and a per-register load-latency scoreboard.
- It accepts instructions from fetch with a valid/ready handshake and presents one instruction per cycle to control and regFile_bypass. It inserts the NOP encoding on hazard, empty buffer or flush.
- It sits between fetch and the decode control/register-file logic.

Parameters:
INSTR_WIDTH, 16, instruction width
REG_SEL_WIDTH, 3, register select width; 2**REG_SEL_WIDTH scoreboard entries
RS_LSB, 8, LSB of the first source field in the instruction
RT_LSB, 5, LSB of the second source field in the instruction
NOP_INSTR, 16'h0800, encoding issued as a bubble
BUF_DEPTH, 2, FIFO entries; power of two, at least 2
LOAD_LATENCY, 1, bubbles a dependent instruction needs after a load issues; legal range 1..3

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  global freeze (data-memory or instruction-memory stall)
flush  in  1  taken branch/jump resolved; drops all buffered younger instructions
fetch_valid  in  1  fetch_instr is valid
fetch_instr  in  INSTR_WIDTH  instruction from fetch
fetch_ready  out  1  FIFO can accept an instruction
issue_instr  out  INSTR_WIDTH  instruction presented to decode (NOP_INSTR when bubble)
issue_valid  out  1  issue_instr is a real instruction popped this cycle
data_hazard  out  1  FIFO head blocked by the scoreboard
issue_is_load  in  1  control decode of issue_instr: it is a memory read
issue_dest  in  REG_SEL_WIDTH  control decode of issue_instr: destination register
occupancy  out  clog2(BUF_DEPTH)+1  current FIFO entry count

Behaviour:
- Reset (synchronous, active-high) clears FIFO and scoreboard. Outputs after reset:
  - fetch_ready=1, issue_valid=0, issue_instr=NOP_INSTR, data_hazard=0, occupancy=0.
  - Reset mid-operation discards all buffered instructions and pending scoreboard counts.
- FIFO: circular buffer with read/write pointers and an explicit count. fetch_ready = (count != BUF_DEPTH).
- Push occurs when fetch_valid & fetch_ready & !stall & !flush.
- Head hazard check:
  - cnt[r] is the per-register scoreboard counter, width clog2(LOAD_LATENCY+1).
  - head_rs = head[RS_LSB+:REG_SEL_WIDTH], head_rt = head[RT_LSB+:REG_SEL_WIDTH].
  - data_hazard = (count != 0) & !flush & (cnt[head_rs] != 0 | cnt[head_rt] != 0).
  - Both fields are always checked (conservative). Register 0 is not special.
- Pop occurs when count != 0 & !data_hazard & !stall & !flush.
- issue_instr is combinational from the FIFO head when a pop occurs, otherwise NOP_INSTR.
- issue_valid = pop. During stall, issue_instr = NOP_INSTR and issue_valid = 0.
- Simultaneous push and pop leaves count unchanged. A push into an empty FIFO is not issued in the same cycle; minimum latency is 1 cycle.
- Scoreboard, applied on each cycle with !stall:
  - Every nonzero counter decrements by 1.
  - Then, if pop & issue_is_load, cnt[issue_dest] = LOAD_LATENCY. The set overrides the decrement on the same register.
  - With stall asserted all counters hold.
- Flush:
  - Count and pointers are cleared, the push is suppressed and issue is a bubble.
  - Scoreboard is NOT cleared, because the loads it tracks are older than the branch. Counters still decrement if !stall.
  - flush with stall: flush wins for the FIFO; counters hold.
- Empty FIFO with no flush: issue a bubble, data_hazard = 0.
- Full FIFO: fetch_ready = 0. A fetch_valid offered then must be held by fetch; the block never drops an accepted instruction except on flush/rst.
- Pointer wrap-around is modulo BUF_DEPTH.
- Expected size: 150-250 lines of RTL.

Test Plan:
- Reset then idle → fetch_ready=1, issue_instr=16'h0800, issue_valid=0, occupancy=0.
- Load-use, LOAD_LATENCY=1: push 16'h8940 (LD r2←r1), bench drives issue_is_load=1, issue_dest=2, then push 16'hDA8C (ADD reads r2) → LD issues at cycle 1; cycle 2 data_hazard=1 with NOP; ADD issues at cycle 3.
- LOAD_LATENCY=3, same pair → exactly 3 NOP cycles between LD and ADD. An independent instruction (rs=r5, rt=r6) placed between them issues with no bubble.
- stall held 4 cycles with a hazard pending → counters frozen, occupancy unchanged, issue_valid=0. After release the dependent instruction issues after the remaining bubble count only.
- Fill FIFO (BUF_DEPTH=4, fetch_valid constant, head blocked) → fetch_ready=0 at occupancy=4. Then flush=1 → next cycle occupancy=0 and fetch_ready=1. A pending load count survives the flush and blocks a later r2 reader.
- 50 random instructions with random stall/fetch_valid → issue_valid instructions exactly match the pushed order with none lost or duplicated, and no reader of a register with a nonzero count issues.
